core_seq: RTL and testbench

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 160 ++++++++++++++++
 tb/tb_core_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// core_seq: multi-cycle fetch/decode/mem/writeback sequencer.
// Drives one shared memory port and the register-file write port.
module core_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [2:0]  mem_mode,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc,
    input  logic [15:0] ex_res,
    input  logic [15:0] ex_ram_addr,
    input  logic [15:0] ex_ram_write,
    input  logic [2:0]  ex_res_target,
    input  logic [2:0]  ex_ram_mode,
    input  logic        ex_res_from_ram,
    input  logic        ex_ram_op,
    input  logic        ex_halt,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        halted,
    output logic        retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] res_q;
    logic [15:0] ram_addr_q;
    logic [15:0] ram_write_q;
    logic [15:0] ld_data_q;
    logic [2:0]  target_q;
    logic [2:0]  ram_mode_q;
    logic        from_ram_q;
    logic        ram_op_q;
    logic        fetch_busy;
    logic [15:0] wb_data;

    assign pc      = pc_q;
    assign instr   = instr_q;
    assign wb_data = from_ram_q ? ld_data_q : res_q;

    // A fetch already on the bus keeps its request even if run drops.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = 16'h0000;
        mem_mode  = 3'b000;
        rf_we     = 1'b0;
        rf_waddr  = 3'd0;
        rf_wdata  = 16'h0000;
        halted    = 1'b0;
        retired   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = !rst && (run || fetch_busy);
            end
            S_MEM: begin
                mem_req   = !rst;
                mem_we    = ram_op_q;
                mem_addr  = ram_addr_q;
                mem_wdata = ram_write_q;
                mem_mode  = ram_mode_q;
            end
            S_WB: begin
                retired  = 1'b1;
                rf_we    = target_q[2] | target_q[1];
                rf_waddr = target_q;
                rf_wdata = wb_data;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= 16'h0000;
            res_q       <= 16'h0000;
            ram_addr_q  <= 16'h0000;
            ram_write_q <= 16'h0000;
            ld_data_q   <= 16'h0000;
            target_q    <= 3'd0;
            ram_mode_q  <= 3'd0;
            from_ram_q  <= 1'b0;
            ram_op_q    <= 1'b0;
            fetch_busy  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_req && mem_ack) begin
                        instr_q    <= mem_rdata;
                        fetch_busy <= 1'b0;
                        state      <= S_DECODE;
                    end else begin
                        fetch_busy <= mem_req;
                    end
                end
                S_DECODE: begin
                    res_q       <= ex_res;
                    ram_addr_q  <= ex_ram_addr;
                    ram_write_q <= ex_ram_write;
                    target_q    <= ex_res_target;
                    ram_mode_q  <= ex_ram_mode;
                    from_ram_q  <= ex_res_from_ram;
                    ram_op_q    <= ex_ram_op;
                    if (ex_halt)
                        state <= S_HALT;
                    else if (ex_res_from_ram)
                        state <= S_MEM;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (!ram_op_q)
                            ld_data_q <= mem_rdata;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (target_q == 3'd1)
                        pc_q <= wb_data;
                    else
                        pc_q <= pc_q + 16'd1;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: directed-step bench for core_seq.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [2:0]  mem_mode;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] ex_res;
    logic [15:0] ex_ram_addr;
    logic [15:0] ex_ram_write;
    logic [2:0]  ex_res_target;
    logic [2:0]  ex_ram_mode;
    logic        ex_res_from_ram;
    logic        ex_ram_op;
    logic        ex_halt;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        halted;
    logic        retired;

    int total = 0;
    int bad   = 0;

    core_seq dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_mode       (mem_mode),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .pc             (pc),
        .ex_res         (ex_res),
        .ex_ram_addr    (ex_ram_addr),
        .ex_ram_write   (ex_ram_write),
        .ex_res_target  (ex_res_target),
        .ex_ram_mode    (ex_ram_mode),
        .ex_res_from_ram(ex_res_from_ram),
        .ex_ram_op      (ex_ram_op),
        .ex_halt        (ex_halt),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .halted         (halted),
        .retired        (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ex_set(input logic [15:0] res, input logic [2:0] tgt,
                          input logic from_ram, input logic op,
                          input logic [15:0] addr, input logic [15:0] wr,
                          input logic [2:0] mode, input logic hlt);
        ex_res          = res;
        ex_res_target   = tgt;
        ex_res_from_ram = from_ram;
        ex_ram_op       = op;
        ex_ram_addr     = addr;
        ex_ram_write    = wr;
        ex_ram_mode     = mode;
        ex_halt         = hlt;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        ex_set(16'h0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        step();
        step();
        // reset state
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_rf_we", 16'(rf_we), 16'h0);
        chk("rst_retired", 16'(retired), 16'h0);
        chk("rst_mem_we", 16'(mem_we), 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_mem_mode", 16'(mem_mode), 16'h0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instr, 16'h0000);

        // first cycle after reset: fetch at 0
        rst = 1'b0;
        run = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'h1111;
        #1;
        chk("f0_req", 16'(mem_req), 16'h1);
        chk("f0_addr", mem_addr, 16'h0000);
        chk("f0_we", 16'(mem_we), 16'h0);

        // ALU: res 1234 -> r3
        ex_set(16'h1234, 3'd3, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        step();
        chk("alu_instr", instr, 16'h1111);
        chk("alu_dec_req", 16'(mem_req), 16'h0);
        step();
        ex_res = 16'hFFFF;
        #1;
        chk("alu_rf_we", 16'(rf_we), 16'h1);
        chk("alu_waddr", 16'(rf_waddr), 16'h3);
        chk("alu_wdata", rf_wdata, 16'h1234);
        chk("alu_retired", 16'(retired), 16'h1);
        chk("alu_pc_wb", pc, 16'h0000);
        mem_rdata = 16'h2222;
        step();
        chk("alu_pc_next", pc, 16'h0001);
        chk("alu_retired_off", 16'(retired), 16'h0);
        chk("alu_rf_we_off", 16'(rf_we), 16'h0);
        chk("f1_addr", mem_addr, 16'h0001);

        // load: 2 wait cycles, BEEF -> r5
        step();
        chk("ld_instr", instr, 16'h2222);
        ex_set(16'h0, 3'd5, 1'b1, 1'b0, 16'h0040, 16'h0, 3'd2, 1'b0);
        mem_ack = 1'b0;
        step();
        chk("ld_req1", 16'(mem_req), 16'h1);
        chk("ld_addr1", mem_addr, 16'h0040);
        chk("ld_we1", 16'(mem_we), 16'h0);
        chk("ld_mode1", 16'(mem_mode), 16'h2);
        step();
        chk("ld_req2", 16'(mem_req), 16'h1);
        chk("ld_addr2", mem_addr, 16'h0040);
        step();
        chk("ld_req3", 16'(mem_req), 16'h1);
        chk("ld_addr3", mem_addr, 16'h0040);
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_rdata = 16'h3333;
        #1;
        chk("ld_wb_req", 16'(mem_req), 16'h0);
        chk("ld_rf_we", 16'(rf_we), 16'h1);
        chk("ld_waddr", 16'(rf_waddr), 16'h5);
        chk("ld_wdata", rf_wdata, 16'hBEEF);
        step();
        chk("ld_pc", pc, 16'h0002);

        // store A5A5 @0080, one wait cycle
        step();
        ex_set(16'h0, 3'd0, 1'b1, 1'b1, 16'h0080, 16'hA5A5, 3'd1, 1'b0);
        mem_ack = 1'b0;
        step();
        chk("st_we1", 16'(mem_we), 16'h1);
        chk("st_wdata1", mem_wdata, 16'hA5A5);
        chk("st_addr1", mem_addr, 16'h0080);
        chk("st_mode1", 16'(mem_mode), 16'h1);
        step();
        chk("st_we2", 16'(mem_we), 16'h1);
        chk("st_wdata2", mem_wdata, 16'hA5A5);
        chk("st_rf_we_mem", 16'(rf_we), 16'h0);
        mem_ack = 1'b1;
        step();
        chk("st_rf_we_wb", 16'(rf_we), 16'h0);
        chk("st_retired", 16'(retired), 16'h1);
        step();
        chk("st_pc", pc, 16'h0003);

        // reset during MEM aborts the access
        step();
        ex_set(16'h0, 3'd4, 1'b1, 1'b0, 16'h0040, 16'h0, 3'd0, 1'b0);
        mem_ack = 1'b0;
        step();
        chk("rm_req_mem", 16'(mem_req), 16'h1);
        rst = 1'b1;
        run = 1'b0;
        step();
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        #1;
        chk("rm_req", 16'(mem_req), 16'h0);
        chk("rm_pc", pc, 16'h0000);
        chk("rm_rf_we", 16'(rf_we), 16'h0);
        chk("rm_halted", 16'(halted), 16'h0);
        // run=0: stays idle, stray ack ignored
        step();
        chk("idle_req", 16'(mem_req), 16'h0);
        chk("idle_instr", instr, 16'h0000);
        chk("idle_pc", pc, 16'h0000);

        // branch to 0010
        run = 1'b1;
        mem_rdata = 16'h4444;
        #1;
        chk("br_req", 16'(mem_req), 16'h1);
        step();
        ex_set(16'h0010, 3'd1, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        step();
        chk("br_rf_we", 16'(rf_we), 16'h0);
        chk("br_retired", 16'(retired), 16'h1);
        step();
        chk("br_pc", pc, 16'h0010);

        // branch to FFFF then NOP wraps to 0
        step();
        ex_set(16'hFFFF, 3'd1, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        step();
        step();
        chk("br2_pc", pc, 16'hFFFF);
        chk("br2_addr", mem_addr, 16'hFFFF);
        step();
        ex_set(16'h5555, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        step();
        chk("nop_rf_we", 16'(rf_we), 16'h0);
        step();
        chk("nop_wrap_pc", pc, 16'h0000);

        // halt
        step();
        ex_set(16'h0, 3'd2, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
        step();
        for (int i = 0; i < 12; i++) begin
            chk("halt_halted", 16'(halted), 16'h1);
            chk("halt_req", 16'(mem_req), 16'h0);
            chk("halt_retired", 16'(retired + rf_we), 16'h0);
            chk("halt_pc", pc, 16'h0000);
            step();
        end

        // reset leaves HALT
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("unhalt_halted", 16'(halted), 16'h0);
        chk("unhalt_req", 16'(mem_req), 16'h1);
        chk("unhalt_addr", mem_addr, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
